// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the Gambling_Tec data-memory arbiter.
// Holds owner encoding, requester indices and the MMIO word addresses.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_KBD  = 2'd2,
    OWN_VGA  = 2'd3
  } owner_e;

  localparam int KBD_IDX = 0;
  localparam int VGA_IDX = 1;

  localparam logic [31:0] ADDR_KBD   = 32'd10;
  localparam logic [31:0] ADDR_CNT   = 32'd16;
  localparam logic [31:0] ADDR_VGA   = 32'd32;
  localparam logic [31:0] ADDR_SYM_A = 32'd4144;
  localparam logic [31:0] ADDR_SYM_B = 32'd4160;
  localparam logic [31:0] ADDR_SYM_C = 32'd4176;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, secondary-master and data_mem signals around the arbiter.
// slave = arbiter side, master = CPU/secondaries/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            cpu_re;
  logic            cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_stall;
  logic [1:0]      s_req;
  logic [1:0]      s_we;
  logic [2*AW-1:0] s_addr;
  logic [2*DW-1:0] s_wdata;
  logic [1:0]      s_ack;
  logic [DW-1:0]   s_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata, s_req, s_we, s_addr, s_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, s_ack, s_rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, s_req, s_we, s_addr, s_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, s_ack, s_rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating wait counter for one secondary requester; at_limit flags starvation.
module starve_counter #(
  parameter int CW    = 4,
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);
  logic [CW-1:0] cnt_r;

  assign at_limit = (cnt_r >= CW'(LIMIT));

  // count waiting cycles, saturating at LIMIT; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && !at_limit) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has fixed priority, keyboard/VGA share idle
// slots round-robin, and a starved requester may steal one cycle from the CPU.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);
  logic [1:0]    elig_s;
  logic [1:0]    at_limit_s;
  logic [1:0]    grant_s;
  logic [1:0]    inc_s;
  logic [1:0]    clr_s;
  logic          force_s;
  owner_e        owner_s;
  logic [1:0]    ack_r;
  logic [DW-1:0] s_rdata_r;
  logic          rr_ptr_r;

  // a requester with an ack in flight is not eligible, preventing double grants
  assign elig_s  = bus.s_req & ~ack_r;
  assign force_s = !rst && (|(elig_s & at_limit_s));

  // owner selection in priority order; during reset the CPU path passes through
  always_comb begin
    owner_s = OWN_IDLE;
    if (rst) begin
      owner_s = OWN_CPU;
    end else if (elig_s[KBD_IDX] && at_limit_s[KBD_IDX]) begin
      owner_s = OWN_KBD;
    end else if (elig_s[VGA_IDX] && at_limit_s[VGA_IDX]) begin
      owner_s = OWN_VGA;
    end else if (bus.cpu_re || bus.cpu_we) begin
      owner_s = OWN_CPU;
    end else if (elig_s[rr_ptr_r]) begin
      owner_s = rr_ptr_r ? OWN_VGA : OWN_KBD;
    end else if (elig_s[~rr_ptr_r]) begin
      owner_s = rr_ptr_r ? OWN_KBD : OWN_VGA;
    end else begin
      owner_s = OWN_IDLE;
    end
  end

  // memory port mux and grant vector
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    grant_s       = 2'b00;
    case (owner_s)
      OWN_CPU: begin
        bus.mem_we    = bus.cpu_we;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_wdata = bus.cpu_wdata;
      end
      OWN_KBD: begin
        bus.mem_we    = bus.s_we[KBD_IDX];
        bus.mem_addr  = bus.s_addr[KBD_IDX*AW +: AW];
        bus.mem_wdata = bus.s_wdata[KBD_IDX*DW +: DW];
        grant_s       = 2'b01;
      end
      OWN_VGA: begin
        bus.mem_we    = bus.s_we[VGA_IDX];
        bus.mem_addr  = bus.s_addr[VGA_IDX*AW +: AW];
        bus.mem_wdata = bus.s_wdata[VGA_IDX*DW +: DW];
        grant_s       = 2'b10;
      end
      default: begin
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        grant_s       = 2'b00;
      end
    endcase
  end

  assign inc_s         = elig_s & ~grant_s;
  assign clr_s         = grant_s | ~bus.s_req;
  assign bus.cpu_stall = force_s;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.s_ack     = ack_r;
  assign bus.s_rdata   = s_rdata_r;

  starve_counter #(.CW(CW), .LIMIT(STARVE_LIMIT)) u_kbd_cnt (
    .clk(clk), .rst(rst), .inc(inc_s[KBD_IDX]), .clr(clr_s[KBD_IDX]), .at_limit(at_limit_s[KBD_IDX])
  );

  starve_counter #(.CW(CW), .LIMIT(STARVE_LIMIT)) u_vga_cnt (
    .clk(clk), .rst(rst), .inc(inc_s[VGA_IDX]), .clr(clr_s[VGA_IDX]), .at_limit(at_limit_s[VGA_IDX])
  );

  // ack/read-data capture and round-robin pointer (points away from last winner)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_r     <= 2'b00;
      s_rdata_r <= '0;
      rr_ptr_r  <= 1'b0;
    end else begin
      ack_r <= grant_s;
      if (|grant_s) begin
        s_rdata_r <= bus.mem_rdata;
        rr_ptr_r  <= grant_s[KBD_IDX];
      end else begin
        s_rdata_r <= s_rdata_r;
        rr_ptr_r  <= rr_ptr_r;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural ownership model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;
  localparam int STARVE = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] ram  [0:8191];
  logic [31:0] mram [0:8191];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(STARVE), .CW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr[12:0]];

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr[12:0]] <= bus.mem_wdata;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // behavioural model: per-cycle owner from the arbitration rules
  initial begin
    int   wcnt [2];
    bit   pend [2];
    bit   elig [2];
    int   ptr;
    int   g;
    bit   force_g;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, exp_rd;
    for (int i = 0; i < 8192; i++) mram[i] = 32'd0;
    mram[32] = 32'd5;
    wcnt[0] = 0; wcnt[1] = 0; pend[0] = 1'b0; pend[1] = 1'b0; ptr = 0; exp_rd = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wcnt[0] = 0; wcnt[1] = 0; pend[0] = 1'b0; pend[1] = 1'b0; ptr = 0;
        chk("m_rst_stall", {63'd0, bus.cpu_stall}, 64'd0);
        chk("m_rst_ack", {62'd0, bus.s_ack}, 64'd0);
        chk("m_rst_mem_addr", {32'd0, bus.mem_addr}, {32'd0, bus.cpu_addr});
        chk("m_rst_mem_we", {63'd0, bus.mem_we}, {63'd0, bus.cpu_we});
      end else begin
        chk("m_ack", {62'd0, bus.s_ack}, {62'd0, pend[1], pend[0]});
        if (pend[0] || pend[1]) chk("m_s_rdata", {32'd0, bus.s_rdata}, {32'd0, exp_rd});
        for (int i = 0; i < 2; i++) elig[i] = bus.s_req[i] && !pend[i];
        g = -1;
        force_g = 1'b0;
        if (elig[0] && wcnt[0] >= STARVE) begin g = 0; force_g = 1'b1; end
        else if (elig[1] && wcnt[1] >= STARVE) begin g = 1; force_g = 1'b1; end
        else if (bus.cpu_re || bus.cpu_we) g = 2;
        else if (elig[ptr]) g = ptr;
        else if (elig[1-ptr]) g = 1 - ptr;
        if (g == 2) begin
          e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wdata = bus.cpu_wdata;
        end else if (g >= 0) begin
          e_we = bus.s_we[g]; e_addr = bus.s_addr[g*32 +: 32]; e_wdata = bus.s_wdata[g*32 +: 32];
        end else begin
          e_we = 1'b0; e_addr = 32'd0; e_wdata = 32'd0;
        end
        chk("m_mem_we", {63'd0, bus.mem_we}, {63'd0, e_we});
        chk("m_mem_addr", {32'd0, bus.mem_addr}, {32'd0, e_addr});
        chk("m_mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, e_wdata});
        chk("m_stall", {63'd0, bus.cpu_stall}, {63'd0, force_g});
        if (g == 2 && bus.cpu_re && !bus.cpu_we)
          chk("m_cpu_rdata", {32'd0, bus.cpu_rdata}, {32'd0, mram[bus.cpu_addr[12:0]]});
        for (int i = 0; i < 2; i++) begin
          pend[i] = (g == i);
          if (!bus.s_req[i] || g == i) wcnt[i] = 0;
          else if (elig[i]) wcnt[i] = (wcnt[i] + 1 > STARVE) ? STARVE : wcnt[i] + 1;
        end
        if (g == 0 || g == 1) begin
          exp_rd = mram[e_addr[12:0]];
          ptr = 1 - g;
        end
        if (e_we) mram[e_addr[12:0]] = e_wdata;
      end
    end
  end

  logic [31:0] rr_addr [5];
  logic [1:0]  rr_ack  [5];

  initial begin
    int n;
    rr_addr[0] = 32'd10; rr_addr[1] = 32'd32; rr_addr[2] = 32'd10; rr_addr[3] = 32'd32; rr_addr[4] = 32'd10;
    rr_ack[0] = 2'b00; rr_ack[1] = 2'b01; rr_ack[2] = 2'b10; rr_ack[3] = 2'b01; rr_ack[4] = 2'b10;
    for (int i = 0; i < 8192; i++) ram[i] = 32'd0;
    ram[32] = 32'd5;
    rst = 1'b1;
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
    bus.s_req = 2'b00; bus.s_we = 2'b00; bus.s_addr = 64'd0; bus.s_wdata = 64'd0;
    repeat (2) @(posedge clk);
    smp();
    chk("reset_stall", {63'd0, bus.cpu_stall}, 64'd0);
    chk("reset_ack", {62'd0, bus.s_ack}, 64'd0);
    chk("reset_rdata", {32'd0, bus.s_rdata}, 64'd0);
    cyc();
    rst = 1'b0;

    // CPU store then load
    cyc();
    bus.cpu_we = 1'b1; bus.cpu_addr = 32'd10; bus.cpu_wdata = 32'h29;
    smp();
    chk("cpu_store_we", {63'd0, bus.mem_we}, 64'd1);
    chk("cpu_store_addr", {32'd0, bus.mem_addr}, 64'd10);
    cyc();
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    smp();
    chk("cpu_load_rdata", {32'd0, bus.cpu_rdata}, 64'h29);
    chk("cpu_load_stall", {63'd0, bus.cpu_stall}, 64'd0);
    chk("cpu_load_ack", {62'd0, bus.s_ack}, 64'd0);

    // VGA read in an idle slot
    cyc();
    bus.cpu_re = 1'b0;
    bus.s_req = 2'b10; bus.s_we = 2'b00; bus.s_addr = {32'd32, 32'd10};
    smp();
    chk("vga_grant_addr", {32'd0, bus.mem_addr}, 64'd32);
    chk("vga_grant_stall", {63'd0, bus.cpu_stall}, 64'd0);
    cyc();
    bus.s_req = 2'b00;
    smp();
    chk("vga_ack", {62'd0, bus.s_ack}, 64'd2);
    chk("vga_rdata", {32'd0, bus.s_rdata}, 64'd5);

    // round-robin with both requesting continuously
    cyc();
    bus.s_req = 2'b11; bus.s_we = 2'b01; bus.s_addr = {32'd32, 32'd10}; bus.s_wdata = {32'd0, 32'h33};
    for (int i = 0; i < 5; i++) begin
      smp();
      chk($sformatf("rr_addr_%0d", i), {32'd0, bus.mem_addr}, {32'd0, rr_addr[i]});
      chk($sformatf("rr_ack_%0d", i), {62'd0, bus.s_ack}, {62'd0, rr_ack[i]});
      if (i < 4) cyc();
    end
    cyc();
    bus.s_req = 2'b00;
    smp();
    chk("rr_last_ack", {62'd0, bus.s_ack}, 64'd1);

    // starvation: CPU loads every cycle while keyboard write waits
    cyc();
    bus.cpu_re = 1'b1; bus.cpu_addr = 32'd32;
    bus.s_req = 2'b01; bus.s_we = 2'b01; bus.s_wdata = {32'd0, 32'h29};
    n = 0;
    while (n < 20) begin
      smp();
      if (bus.cpu_stall) break;
      n++;
      cyc();
    end
    chk("starve_wait_cycles", n, 64'd8);
    chk("starve_mem_we", {63'd0, bus.mem_we}, 64'd1);
    chk("starve_mem_addr", {32'd0, bus.mem_addr}, 64'd10);
    cyc();
    bus.s_req = 2'b00;
    smp();
    chk("starve_ack", {62'd0, bus.s_ack}, 64'd1);
    chk("starve_unstall", {63'd0, bus.cpu_stall}, 64'd0);
    chk("starve_ram10", {32'd0, ram[10]}, 64'h29);

    // collision: CPU store and keyboard write to the same word
    cyc();
    bus.cpu_re = 1'b0; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd10; bus.cpu_wdata = 32'h11;
    bus.s_req = 2'b01;
    smp();
    chk("coll_cpu_wdata", {32'd0, bus.mem_wdata}, 64'h11);
    cyc();
    bus.cpu_we = 1'b0;
    smp();
    chk("coll_kbd_wdata", {32'd0, bus.mem_wdata}, 64'h29);
    chk("coll_ram_mid", {32'd0, ram[10]}, 64'h11);
    cyc();
    bus.s_req = 2'b00;
    smp();
    chk("coll_ack", {62'd0, bus.s_ack}, 64'd1);
    chk("coll_ram_final", {32'd0, ram[10]}, 64'h29);

    // reset in the VGA grant cycle
    cyc();
    bus.s_req = 2'b10; bus.s_we = 2'b00;
    #2 rst = 1'b1;
    smp();
    chk("rst_mid_stall", {63'd0, bus.cpu_stall}, 64'd0);
    cyc();
    smp();
    chk("rst_mid_no_ack", {62'd0, bus.s_ack}, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.s_req = 2'b11; bus.s_we = 2'b01;
    smp();
    chk("rst_ptr_kbd_first", {32'd0, bus.mem_addr}, 64'd10);
    cyc();
    smp();
    chk("rst_vga_regrant", {32'd0, bus.mem_addr}, 64'd32);
    chk("rst_kbd_ack", {62'd0, bus.s_ack}, 64'd1);
    cyc();
    bus.s_req = 2'b00;
    smp();
    chk("rst_vga_ack", {62'd0, bus.s_ack}, 64'd2);
    chk("rst_vga_rdata", {32'd0, bus.s_rdata}, 64'd5);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
